// File: rtl/l2c_maint_engine_if.sv
// l2c_maint_engine_if: control-register and tag/data-pipeline signals of the
// L2C maintenance engine, bundled for connection to l2c_maint_engine.
// Optional: L2C_MAINT_STATS_EN adds the o_stat_wb_cnt writeback counter.
interface l2c_maint_engine_if #(
    parameter int IDX_W = 9,
    parameter int WAY_W = 3,
    parameter int TAG_W = 17
);
    logic             i_ctl_req;
    logic [1:0]       i_ctl_op;
    logic [IDX_W-1:0] i_ctl_start_idx;
    logic [IDX_W-1:0] i_ctl_end_idx;
    logic             i_ctl_abort;
    logic             i_idle;
    logic             i_maint_clear_ack;
    logic             i_maint_flush_dirty;
    logic             i_maint_flush_clean;
    logic [WAY_W-1:0] i_maint_hit_way;
    logic [TAG_W-1:0] i_old_tag;
    logic             i_writeback_ack;
    logic             i_wb_ack_broadcast;
    logic [31:0]      i_wb_ack_adr;
    logic [IDX_W-1:0] o_index;
    logic [WAY_W-1:0] o_way;
    logic [TAG_W-1:0] o_old_tag;
    logic             o_writeback_req;
    logic             o_maintenance;
    logic             o_maintenance_clear;
    logic             o_maintenance_req;
    logic [3:0]       o_wb_outstanding;
    logic             o_ctl_maint_ack;
    logic             o_ctl_aborted;
`ifdef L2C_MAINT_STATS_EN
    logic [15:0]      o_stat_wb_cnt;
`endif

    // Engine side
    modport slave (
        input  i_ctl_req, i_ctl_op, i_ctl_start_idx, i_ctl_end_idx, i_ctl_abort,
        input  i_idle, i_maint_clear_ack, i_maint_flush_dirty, i_maint_flush_clean,
        input  i_maint_hit_way, i_old_tag, i_writeback_ack,
        input  i_wb_ack_broadcast, i_wb_ack_adr,
        output o_index, o_way, o_old_tag, o_writeback_req, o_maintenance,
        output o_maintenance_clear, o_maintenance_req, o_wb_outstanding,
        output o_ctl_maint_ack, o_ctl_aborted
`ifdef L2C_MAINT_STATS_EN
        , output o_stat_wb_cnt
`endif
    );

    // Control-register block / cache pipeline side
    modport master (
        output i_ctl_req, i_ctl_op, i_ctl_start_idx, i_ctl_end_idx, i_ctl_abort,
        output i_idle, i_maint_clear_ack, i_maint_flush_dirty, i_maint_flush_clean,
        output i_maint_hit_way, i_old_tag, i_writeback_ack,
        output i_wb_ack_broadcast, i_wb_ack_adr,
        input  o_index, o_way, o_old_tag, o_writeback_req, o_maintenance,
        input  o_maintenance_clear, o_maintenance_req, o_wb_outstanding,
        input  o_ctl_maint_ack, o_ctl_aborted
`ifdef L2C_MAINT_STATS_EN
        , input o_stat_wb_cnt
`endif
    );
endinterface

// File: rtl/l2c_maint_engine.sv
// l2c_maint_engine: sweeps an index range performing clear, flush or
// flush-then-clear; flush writebacks are tracked until the memory side
// broadcasts their completion, and the final ack waits for all of them.
// Optional: define L2C_MAINT_STATS_EN to add o_stat_wb_cnt (writebacks
// pushed during the current operation, saturating).
module l2c_maint_engine #(
    parameter int IDX_W    = 9,
    parameter int WAY_W    = 3,
    parameter int TAG_W    = 17,
    parameter int LINE_W   = 6,
    parameter int WB_DEPTH = 4
) (
    input logic               Clk,
    input logic               Reset_n,
    l2c_maint_engine_if.slave bus
);
    // Line address width: the writeback address without its line offset.
    localparam int LA_W = TAG_W + IDX_W;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_IDLE,
        CLEAR_OP,
        FLUSH_OP,
        WRITEBACK,
        IDX_INC,
        DRAIN,
        REPLY
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [1:0]          op;
    logic [IDX_W-1:0]    cnt;
    logic [IDX_W-1:0]    end_idx;
    logic [WAY_W-1:0]    way;
    logic [TAG_W-1:0]    old_tag;
    logic                abort_flag;
    logic [WB_DEPTH-1:0] trk_valid;
    logic [LA_W-1:0]     trk_adr [WB_DEPTH];
    logic [WB_DEPTH-1:0] free_sel;
    logic [WB_DEPTH-1:0] clr_sel;
    logic [3:0]          wb_count;
    logic                full;
    logic                push;
    logic                last_idx;
    logic [LA_W-1:0]     push_adr;
    logic [LA_W-1:0]     bcast_adr;
    logic                unused_line_bits;

    assign push      = (state == WRITEBACK) && bus.i_writeback_ack;
    assign push_adr  = {old_tag, cnt};
    assign bcast_adr = bus.i_wb_ack_adr[31:LINE_W];
    assign last_idx  = (cnt == end_idx);
    assign full      = (wb_count == 4'(WB_DEPTH));
    assign unused_line_bits = ^bus.i_wb_ack_adr[LINE_W-1:0];

    // Tracker occupancy, lowest free slot (one-hot) and broadcast matches.
    // A slot being filled is invalid this cycle, so a broadcast can never
    // clear the line that is being pushed alongside it.
    always_comb begin
        wb_count = '0;
        free_sel = '0;
        clr_sel  = '0;
        for (int i = WB_DEPTH - 1; i >= 0; i--) begin
            wb_count = wb_count + 4'(trk_valid[i]);
            if (!trk_valid[i]) begin
                free_sel    = '0;
                free_sel[i] = 1'b1;
            end
            clr_sel[i] = bus.i_wb_ack_broadcast && trk_valid[i] &&
                         (trk_adr[i] == bcast_adr);
        end
    end

    // Next-state logic for the sweep controller.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (bus.i_ctl_req) state_nxt = WAIT_IDLE;
            end
            WAIT_IDLE: begin
                if (op == 2'b00 || abort_flag) state_nxt = REPLY;
                else if (bus.i_idle)           state_nxt = op[1] ? FLUSH_OP : CLEAR_OP;
            end
            CLEAR_OP: begin
                if (bus.i_maint_clear_ack) state_nxt = IDX_INC;
            end
            FLUSH_OP: begin
                // A dirty line with a full tracker holds here until a
                // broadcast frees a slot.
                if (bus.i_maint_flush_dirty) begin
                    if (!full) state_nxt = WRITEBACK;
                end else if (bus.i_maint_flush_clean) begin
                    state_nxt = (op == 2'b11) ? CLEAR_OP : IDX_INC;
                end
            end
            WRITEBACK: begin
                // Rescan the same index for further dirty ways.
                if (bus.i_writeback_ack) state_nxt = FLUSH_OP;
            end
            IDX_INC: begin
                if (last_idx || abort_flag) state_nxt = DRAIN;
                else                        state_nxt = op[1] ? FLUSH_OP : CLEAR_OP;
            end
            DRAIN: begin
                if (wb_count == 4'd0) state_nxt = REPLY;
            end
            REPLY: begin
                if (!bus.i_ctl_req) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, latched request, index counter, pending writeback and tracker valids.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= IDLE;
            op         <= '0;
            cnt        <= '0;
            end_idx    <= '0;
            way        <= '0;
            old_tag    <= '0;
            abort_flag <= 1'b0;
            trk_valid  <= '0;
        end else begin
            state      <= state_nxt;
            abort_flag <= (state == IDLE) ? 1'b0 : (abort_flag | bus.i_ctl_abort);
            if (state == IDLE && bus.i_ctl_req) begin
                op      <= bus.i_ctl_op;
                cnt     <= bus.i_ctl_start_idx;
                end_idx <= bus.i_ctl_end_idx;
            end
            // Wraps modulo 2^IDX_W, which makes start > end sweeps legal.
            if (state == IDX_INC && !last_idx && !abort_flag) begin
                cnt <= cnt + 1'b1;
            end
            if (state == FLUSH_OP && bus.i_maint_flush_dirty && !full) begin
                way     <= bus.i_maint_hit_way;
                old_tag <= bus.i_old_tag;
            end
            trk_valid <= (trk_valid & ~clr_sel) | (push ? free_sel : '0);
        end
    end

    // Tracker line addresses; only meaningful where the valid bit is set.
    always_ff @(posedge Clk) begin
        for (int i = 0; i < WB_DEPTH; i++) begin
            if (push && free_sel[i]) trk_adr[i] <= push_adr;
        end
    end

`ifdef L2C_MAINT_STATS_EN
    logic [15:0] stat_wb_cnt;

    // Writebacks pushed during the current operation, held through Reply.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            stat_wb_cnt <= '0;
        end else if (state == IDLE && bus.i_ctl_req) begin
            stat_wb_cnt <= '0;
        end else if (push && stat_wb_cnt != 16'hFFFF) begin
            stat_wb_cnt <= stat_wb_cnt + 16'd1;
        end
    end

    assign bus.o_stat_wb_cnt = stat_wb_cnt;
`endif

    assign bus.o_index             = cnt;
    assign bus.o_way               = way;
    assign bus.o_old_tag           = old_tag;
    assign bus.o_writeback_req     = (state == WRITEBACK);
    assign bus.o_maintenance       = (state != IDLE);
    assign bus.o_maintenance_clear = (state == CLEAR_OP);
    assign bus.o_maintenance_req   = (state == CLEAR_OP) || (state == FLUSH_OP);
    assign bus.o_wb_outstanding    = wb_count;
    assign bus.o_ctl_maint_ack     = (state == REPLY);
    assign bus.o_ctl_aborted       = (state == REPLY) && abort_flag;
endmodule

// File: tb/tb_l2c_maint_engine.sv
// tb_l2c_maint_engine: directed scenarios for l2c_maint_engine. Stimulus
// pushes the expected clear/writeback/ack events into a queue; a monitor
// pops and compares whenever the engine presents one. A responder models
// the cache's dirty lines and answers flush scans.
module tb_l2c_maint_engine;
    localparam int IDX_W    = 9;
    localparam int WAY_W    = 3;
    localparam int TAG_W    = 17;
    localparam int LINE_W   = 6;
    localparam int WB_DEPTH = 4;

    localparam int K_CLR = 0;
    localparam int K_WB  = 1;
    localparam int K_ACK = 2;

    typedef struct {
        int kind;
        int idx;
        int way;
        int tag;
        int abt;
    } exp_t;

    typedef struct {
        int idx;
        int way;
        int tag;
    } line_t;

    logic  clk   = 1'b0;
    logic  rst_n = 1'b0;
    logic  wb_ack_en  = 1'b1;
    logic  clr_ack_en = 1'b1;
    logic  ack_prev   = 1'b0;
    int    checks = 0;
    int    errors = 0;
    exp_t  expq[$];
    line_t dirtyq[$];

    always #5 clk = ~clk;

    l2c_maint_engine_if #(.IDX_W(IDX_W), .WAY_W(WAY_W), .TAG_W(TAG_W)) bus ();

    l2c_maint_engine #(
        .IDX_W(IDX_W), .WAY_W(WAY_W), .TAG_W(TAG_W),
        .LINE_W(LINE_W), .WB_DEPTH(WB_DEPTH)
    ) dut (
        .Clk(clk),
        .Reset_n(rst_n),
        .bus(bus)
    );

    task automatic check(string name, longint act, longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic expect_ev(int kind, int idx, int way, int tag, int abt);
        exp_t e;
        e.kind = kind; e.idx = idx; e.way = way; e.tag = tag; e.abt = abt;
        expq.push_back(e);
    endtask

    task automatic observe(int kind, int idx, int way, int tag, int abt);
        exp_t e;
        if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d idx %0d way %0d tag %0d, required none",
                     kind, idx, way, tag);
            return;
        end
        e = expq.pop_front();
        check("event_kind", kind, e.kind);
        if (e.kind == K_CLR || e.kind == K_WB) check("event_index", idx, e.idx);
        if (e.kind == K_WB) begin
            check("wb_way", way, e.way);
            check("wb_old_tag", tag, e.tag);
        end
        if (e.kind == K_ACK) check("ack_aborted", abt, e.abt);
    endtask

    // Monitor: compares every presented event against the scoreboard queue.
    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            ack_prev = 1'b0;
        end else begin
            if (bus.o_maintenance_clear && bus.i_maint_clear_ack)
                observe(K_CLR, int'(bus.o_index), 0, 0, 0);
            if (bus.o_writeback_req && bus.i_writeback_ack)
                observe(K_WB, int'(bus.o_index), int'(bus.o_way), int'(bus.o_old_tag), 0);
            if (bus.o_ctl_maint_ack && !ack_prev)
                observe(K_ACK, 0, 0, 0, int'(bus.o_ctl_aborted));
            ack_prev = bus.o_ctl_maint_ack;
        end
    end

    // Responder: cache model answering clear, flush scans and writebacks.
    always @(negedge clk) begin
        int hit;
        #1;
        bus.i_writeback_ack     = wb_ack_en;
        bus.i_maint_clear_ack   = clr_ack_en;
        bus.i_maint_flush_dirty = 1'b0;
        bus.i_maint_flush_clean = 1'b0;
        bus.i_maint_hit_way     = '0;
        bus.i_old_tag           = '0;
        if (rst_n && bus.o_writeback_req && wb_ack_en) begin
            hit = -1;
            for (int i = 0; i < dirtyq.size(); i++)
                if (hit < 0 && dirtyq[i].idx == int'(bus.o_index) && dirtyq[i].way == int'(bus.o_way))
                    hit = i;
            if (hit >= 0) dirtyq.delete(hit);
        end
        if (rst_n && bus.o_maintenance_req && !bus.o_maintenance_clear) begin
            hit = -1;
            for (int i = 0; i < dirtyq.size(); i++)
                if (hit < 0 && dirtyq[i].idx == int'(bus.o_index)) hit = i;
            if (hit >= 0) begin
                bus.i_maint_flush_dirty = 1'b1;
                bus.i_maint_hit_way     = WAY_W'(dirtyq[hit].way);
                bus.i_old_tag           = TAG_W'(dirtyq[hit].tag);
            end else begin
                bus.i_maint_flush_clean = 1'b1;
            end
        end
    end

    task automatic add_dirty(int idx, int way, int tag);
        line_t l;
        l.idx = idx; l.way = way; l.tag = tag;
        dirtyq.push_back(l);
    endtask

    task automatic start_op(int op, int s, int e);
        @(negedge clk);
        bus.i_ctl_op        = 2'(op);
        bus.i_ctl_start_idx = IDX_W'(s);
        bus.i_ctl_end_idx   = IDX_W'(e);
        bus.i_ctl_req       = 1'b1;
    endtask

    task automatic wait_ack(string name, int budget);
        int n = 0;
        while (!bus.o_ctl_maint_ack && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!bus.o_ctl_maint_ack) begin
            checks++;
            errors++;
            $display("FAIL %s_ack_timeout: got no ack in %0d cycles, required ack", name, budget);
        end
    endtask

    task automatic wait_outst(string name, int n_req, int budget);
        int n = 0;
        while (int'(bus.o_wb_outstanding) != n_req && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_outstanding"}, bus.o_wb_outstanding, n_req);
    endtask

    task automatic finish_op(string name);
        repeat (3) @(negedge clk);
        check({name, "_ack_held"}, bus.o_ctl_maint_ack, 1);
        bus.i_ctl_req = 1'b0;
        repeat (2) @(negedge clk);
        check({name, "_back_idle"}, bus.o_maintenance, 0);
        check({name, "_ack_dropped"}, bus.o_ctl_maint_ack, 0);
    endtask

    task automatic broadcast(int tag, int idx);
        @(negedge clk);
        bus.i_wb_ack_adr       = {TAG_W'(tag), IDX_W'(idx), LINE_W'(0)};
        bus.i_wb_ack_broadcast = 1'b1;
        @(negedge clk);
        bus.i_wb_ack_broadcast = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        bus.i_ctl_req = 0; bus.i_ctl_op = 0; bus.i_ctl_start_idx = 0; bus.i_ctl_end_idx = 0;
        bus.i_ctl_abort = 0; bus.i_idle = 1; bus.i_maint_clear_ack = 0;
        bus.i_maint_flush_dirty = 0; bus.i_maint_flush_clean = 0; bus.i_maint_hit_way = 0;
        bus.i_old_tag = 0; bus.i_writeback_ack = 0; bus.i_wb_ack_broadcast = 0; bus.i_wb_ack_adr = 0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_maintenance", bus.o_maintenance, 0);
        check("rst_ack", bus.o_ctl_maint_ack, 0);
        check("rst_wb_req", bus.o_writeback_req, 0);
        check("rst_outstanding", bus.o_wb_outstanding, 0);
        check("rst_index", bus.o_index, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Full clear sweep 0..511
        for (int i = 0; i < 512; i++) expect_ev(K_CLR, i, 0, 0, 0);
        expect_ev(K_ACK, 0, 0, 0, 0);
        start_op(1, 0, 511);
        wait_ack("clear_all", 3000);
        finish_op("clear_all");

        // Single index flush with two dirty ways
        add_dirty(5, 2, 'h1A5A5);
        add_dirty(5, 6, 'h0C3C3);
        expect_ev(K_WB, 5, 2, 'h1A5A5, 0);
        expect_ev(K_WB, 5, 6, 'h0C3C3, 0);
        expect_ev(K_ACK, 0, 0, 0, 0);
        start_op(2, 5, 5);
        wait_outst("flush2", 2, 100);
        repeat (4) @(negedge clk);
        check("flush2_ack_waits", bus.o_ctl_maint_ack, 0);
        check("flush2_busy", bus.o_maintenance, 1);
        broadcast('h1A5A5, 5);
        check("flush2_one_left", bus.o_wb_outstanding, 1);
        broadcast('h0C3C3, 5);
        wait_ack("flush2", 100);
        finish_op("flush2");

        // Tracker full stall: five dirty lines, four slots
        for (int w = 0; w < 5; w++) begin
            add_dirty(7, w, 'h100 + w);
            expect_ev(K_WB, 7, w, 'h100 + w, 0);
        end
        expect_ev(K_ACK, 0, 0, 0, 0);
        start_op(2, 7, 7);
        wait_outst("stall", 4, 100);
        repeat (3) @(negedge clk);
        check("stall_wb_req", bus.o_writeback_req, 0);
        check("stall_maint_req", bus.o_maintenance_req, 1);
        check("stall_clear", bus.o_maintenance_clear, 0);
        broadcast('h1FFFF, 7);
        check("stall_nomatch_bcast", bus.o_wb_outstanding, 4);
        broadcast('h100, 7);
        wait_outst("stall_resume", 4, 50);
        for (int w = 1; w < 5; w++) broadcast('h100 + w, 7);
        check("stall_drained", bus.o_wb_outstanding, 0);
        wait_ack("stall", 100);
        finish_op("stall");

        // Flush+clear with wrap 510..1
        add_dirty(511, 1, 'h0ABCD);
        add_dirty(0, 4, 'h01234);
        expect_ev(K_CLR, 510, 0, 0, 0);
        expect_ev(K_WB, 511, 1, 'h0ABCD, 0);
        expect_ev(K_CLR, 511, 0, 0, 0);
        expect_ev(K_WB, 0, 4, 'h01234, 0);
        expect_ev(K_CLR, 0, 0, 0, 0);
        expect_ev(K_CLR, 1, 0, 0, 0);
        expect_ev(K_ACK, 0, 0, 0, 0);
        start_op(3, 510, 1);
        wait_outst("wrap", 2, 100);
        broadcast('h0ABCD, 511);
        broadcast('h01234, 0);
        wait_ack("wrap", 100);
        finish_op("wrap");

        // Abort at index 3 of 0..100
        for (int i = 0; i < 4; i++) expect_ev(K_CLR, i, 0, 0, 0);
        expect_ev(K_ACK, 0, 0, 0, 1);
        start_op(1, 0, 100);
        n = 0;
        while (!(bus.o_maintenance_clear && int'(bus.o_index) == 3) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("abort_reached_idx3", bus.o_index, 3);
        bus.i_ctl_abort = 1'b1;
        @(negedge clk);
        bus.i_ctl_abort = 1'b0;
        wait_ack("abort", 100);
        finish_op("abort");

        // Illegal op: immediate ack, abort flag no longer set
        expect_ev(K_ACK, 0, 0, 0, 0);
        start_op(0, 20, 30);
        wait_ack("illegal", 20);
        finish_op("illegal");

        // Asynchronous reset while a writeback is pending
        add_dirty(9, 0, 'h11);
        add_dirty(9, 1, 'h22);
        add_dirty(9, 2, 'h33);
        expect_ev(K_WB, 9, 0, 'h11, 0);
        expect_ev(K_WB, 9, 1, 'h22, 0);
        start_op(2, 9, 9);
        wait_outst("rst_wb", 2, 100);
        wb_ack_en = 1'b0;
        n = 0;
        while (!bus.o_writeback_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rst_wb_in_writeback", bus.o_writeback_req, 1);
        #3 rst_n = 1'b0;
        #1;
        check("rst_wb_idle", bus.o_maintenance, 0);
        check("rst_wb_req_low", bus.o_writeback_req, 0);
        check("rst_wb_tracker_empty", bus.o_wb_outstanding, 0);
        bus.i_ctl_req = 1'b0;
        wb_ack_en = 1'b1;
        dirtyq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        check("scoreboard_drained", expq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
